// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned shift-add multiplier built around a carry-lookahead adder
module carry_lookahead_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_add1,
  input  logic [WIDTH-1:0] i_add2,
  output logic [WIDTH:0]   o_result
);
  logic [WIDTH:0] w_c;
  always_comb begin
    w_c = '0;
    for (int i = 0; i < WIDTH; i++)
      w_c[i+1] = (i_add1[i] & i_add2[i]) | ((i_add1[i] | i_add2[i]) & w_c[i]);
  end
  assign o_result = {w_c[WIDTH], i_add1 ^ i_add2 ^ w_c[WIDTH-1:0]};
endmodule

module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t             state_q;
  logic [WIDTH-1:0]   mcand_q, acc_hi_q, acc_lo_q, add2;
  logic [CW-1:0]      count_q;
  logic               busy_q, done_q;
  logic [2*WIDTH-1:0] product_q, acc_d;
  logic [WIDTH:0]     sum;
  assign add2 = acc_lo_q[0] ? mcand_q : '0;
  carry_lookahead_adder #(.WIDTH(WIDTH)) u_add (
    .i_add1  (acc_hi_q),
    .i_add2  (add2),
    .o_result(sum)
  );
  // carry-out lands in the top bit, so no partial product is ever lost
  assign acc_d = {sum, acc_lo_q[WIDTH-1:1]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else if (state_q == IDLE) begin
      if (start) begin
        mcand_q  <= a;
        acc_hi_q <= '0;
        acc_lo_q <= b;
        count_q  <= '0;
        busy_q   <= 1'b1;
        state_q  <= CALC;
      end
    end else if (state_q == CALC) begin
      {acc_hi_q, acc_lo_q} <= acc_d;
      count_q <= count_q + CW'(1);
      if (count_q == CW'(WIDTH - 1)) begin
        product_q <= acc_d;
        busy_q    <= 1'b0;
        done_q    <= 1'b1;
        state_q   <= DONE;
      end
    end else begin
      done_q  <= 1'b0;
      state_q <= IDLE;
    end
  end
  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;
endmodule
